luma_interp_mac: RTL

Sequential 8-tap H.265 luma fractional-sample interpolation engine.
- Accepts one reference sample per beat and selects the standard luma filter coefficient for each tap from a 2-bit fractional phase.
- Accumulates the taps through a registered multiply-add stage, one tap per accepted beat.
- Sits directly upstream of the multiply-add primitive, driving its a/b/c operands and consuming its registered p.
- Delivers one filtered value per 8 samples to the prediction sample buffer.

---
 rtl/h265_interp_pkg.sv | 22 ++
 rtl/luma_interp_mac_if.sv | 25 ++
 rtl/multadd.sv | 30 +++
 rtl/luma_interp_mac.sv | 93 +++++++++
 4 files changed

// File: rtl/h265_interp_pkg.sv
// rtl/h265_interp_pkg.sv - shared types and constants for the luma interpolation MAC
package h265_interp_pkg;

  localparam int ACC_BITS_DEF = 20;
  localparam int ROUND_OFS    = 32;
  localparam int ROUND_SHIFT  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Standard H.265 8-tap luma filters indexed [phase][tap]
  localparam logic signed [7:0] LUMA_COEF [4][8] = '{
    '{ 8'sd0,  8'sd0,  8'sd0,   8'sd64,  8'sd0,   8'sd0,   8'sd0,  8'sd0 },
    '{-8'sd1,  8'sd4, -8'sd10,  8'sd58,  8'sd17, -8'sd5,   8'sd1,  8'sd0 },
    '{-8'sd1,  8'sd4, -8'sd11,  8'sd40,  8'sd40, -8'sd11,  8'sd4, -8'sd1 },
    '{ 8'sd0,  8'sd1, -8'sd5,   8'sd17,  8'sd58, -8'sd10,  8'sd4, -8'sd1 }
  };

endpackage

// File: rtl/luma_interp_mac_if.sv
// rtl/luma_interp_mac_if.sv - sample input and filtered result handshake bundle
interface luma_interp_mac_if
  import h265_interp_pkg::*;
#(
  parameter int BIT_DEPTH = 8,
  parameter int ACC_BITS  = ACC_BITS_DEF
);
  logic [1:0]                 frac;
  logic                       in_valid;
  logic                       in_ready;
  logic signed [BIT_DEPTH:0]  in_sample;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [ACC_BITS-1:0] out_data;

  modport master (
    output frac, in_valid, in_sample, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  frac, in_valid, in_sample, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/multadd.sv
// rtl/multadd.sv - registered signed multiply-add primitive, p <= a*b + c
module multadd #(
  parameter int a_bits = 9,
  parameter int b_bits = 8,
  parameter int c_bits = 20,
  parameter int p_bits = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [a_bits-1:0] a,
  input  logic signed [b_bits-1:0] b,
  input  logic signed [c_bits-1:0] c,
  output logic signed [p_bits-1:0] p
);
  logic signed [a_bits+b_bits-1:0] prod;
  logic signed [p_bits-1:0]        prod_ext;
  logic signed [p_bits-1:0]        c_ext;

  assign prod     = a * b;
  assign prod_ext = p_bits'(prod);
  assign c_ext    = p_bits'(c);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p <= '0;
    end else begin
      p <= prod_ext + c_ext;
    end
  end
endmodule

// File: rtl/luma_interp_mac.sv
// rtl/luma_interp_mac.sv - sequential 8-tap luma interpolation; LUMA_INTERP_CLIP_EN selects rounded/clipped pixel output
module luma_interp_mac
  import h265_interp_pkg::*;
#(
  parameter int BIT_DEPTH = 8,
  parameter int ACC_BITS  = ACC_BITS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  luma_interp_mac_if.slave bus
);
  state_e                     state, state_nxt;
  logic [2:0]                 tap_cnt;
  logic [1:0]                 phase_q;
  logic [1:0]                 phase_sel;
  logic                       beat;
  logic signed [BIT_DEPTH:0]  mac_a;
  logic signed [7:0]          mac_b;
  logic signed [ACC_BITS-1:0] mac_c;
  logic signed [ACC_BITS-1:0] mac_p;

  assign bus.in_ready  = (state != OUT);
  assign bus.out_valid = (state == OUT);
  assign beat          = bus.in_valid && bus.in_ready;
  // The first beat must use the incoming phase before it is latched
  assign phase_sel     = (state == IDLE) ? bus.frac : phase_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      tap_cnt <= '0;
      phase_q <= '0;
    end else begin
      state <= state_nxt;
      if (beat) begin
        tap_cnt <= tap_cnt + 3'd1;
      end
      if (beat && state == IDLE) begin
        phase_q <= bus.frac;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    mac_a     = '0;
    mac_b     = '0;
    mac_c     = mac_p;
    if (beat) begin
      mac_a = bus.in_sample;
      mac_b = LUMA_COEF[phase_sel][tap_cnt];
      mac_c = (tap_cnt == 3'd0) ? '0 : mac_p;
    end
    case (state)
      IDLE:    if (beat) state_nxt = ACC;
      ACC:     if (beat && tap_cnt == 3'd7) state_nxt = OUT;
      OUT:     if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  multadd #(
    .a_bits(BIT_DEPTH + 1),
    .b_bits(8),
    .c_bits(ACC_BITS),
    .p_bits(ACC_BITS)
  ) u_multadd (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (mac_a),
    .b    (mac_b),
    .c    (mac_c),
    .p    (mac_p)
  );

`ifdef LUMA_INTERP_CLIP_EN
  localparam logic signed [ACC_BITS-1:0] PIX_MAX = ACC_BITS'((1 << BIT_DEPTH) - 1);
  logic signed [ACC_BITS-1:0] rnd;

  assign rnd = (mac_p + ACC_BITS'(ROUND_OFS)) >>> ROUND_SHIFT;

  always_comb begin
    bus.out_data = rnd;
    if (rnd < 0) begin
      bus.out_data = '0;
    end else if (rnd > PIX_MAX) begin
      bus.out_data = PIX_MAX;
    end
  end
`else
  assign bus.out_data = mac_p;
`endif
endmodule
